// File: rtl/xoodyak_op_sequencer.sv
// Xoodyak operation sequencer: walks a latched program of 4-bit opcodes,
// issuing one core start per non-idle op and watching each for completion or timeout.
module xoodyak_op_sequencer #(
    parameter int TIMEOUT = 64,
    parameter int MAX_OPS = 8
) (
    input  logic                   eph1,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [4*MAX_OPS-1:0]   cmd_prog,
    input  logic [3:0]             cmd_len,
    output logic                   core_start,
    output logic [3:0]             core_opmode,
    input  logic                   core_finished,
    output logic                   seq_busy,
    output logic                   seq_done,
    output logic                   seq_error,
    output logic [2:0]             step_idx
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

    state_t               state_r, nxt_state_s;
    logic [2:0]           step_r, nxt_step_s;
    logic [CNT_W-1:0]     cnt_r, nxt_cnt_s;
    logic [4*MAX_OPS-1:0] prog_r, nxt_prog_s;
    logic [3:0]           len_r, nxt_len_s;
    logic                 err_r, nxt_err_s;
    logic                 start_r, busy_r, done_r;
    logic [3:0]           opmode_r;
    logic [3:0]           cur_op_s, nxt_op_s;
    logic                 last_step_s, legal_s;

    function automatic logic [3:0] op_at(input logic [4*MAX_OPS-1:0] prog, input logic [2:0] idx);
        logic [3:0] op;
        op = 4'd0;
        for (int k = 0; k < MAX_OPS; k++) begin
            op = op | (prog[4*k +: 4] & {4{k == int'(idx)}});
        end
        return op;
    endfunction

    assign cur_op_s    = op_at(prog_r, step_r);
    assign nxt_op_s    = op_at(nxt_prog_s, nxt_step_s);
    assign last_step_s = ({1'b0, step_r} == (len_r - 4'd1));
    assign legal_s     = (cmd_len != 4'd0) && (int'(cmd_len) <= MAX_OPS) && (cmd_prog[2:0] == 3'd1);

    // Next-state and next-datapath computation for the program walk.
    always_comb begin
        nxt_state_s = state_r;
        nxt_step_s  = step_r;
        nxt_cnt_s   = cnt_r;
        nxt_prog_s  = prog_r;
        nxt_len_s   = len_r;
        nxt_err_s   = err_r;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid) begin
                    nxt_prog_s  = cmd_prog;
                    nxt_len_s   = cmd_len;
                    nxt_step_s  = 3'd0;
                    nxt_err_s   = !legal_s;
                    nxt_state_s = legal_s ? ST_ISSUE : ST_ERR;
                end else begin
                    nxt_state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                // An idle opcode is stepped over as if it had completed instantly.
                if (cur_op_s[2:0] == 3'd0) begin
                    if (last_step_s) begin
                        nxt_state_s = ST_DONE;
                    end else begin
                        nxt_step_s  = step_r + 3'd1;
                        nxt_state_s = ST_ISSUE;
                    end
                end else begin
                    nxt_cnt_s   = {CNT_W{1'b0}};
                    nxt_state_s = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (core_finished) begin
                    if (last_step_s) begin
                        nxt_state_s = ST_DONE;
                    end else begin
                        nxt_step_s  = step_r + 3'd1;
                        nxt_state_s = ST_ISSUE;
                    end
                end else if (cnt_r == CNT_W'(TIMEOUT - 1)) begin
                    nxt_err_s   = 1'b1;
                    nxt_state_s = ST_ERR;
                end else begin
                    nxt_cnt_s   = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_DONE: nxt_state_s = ST_IDLE;
            ST_ERR:  nxt_state_s = ST_IDLE;
            default: nxt_state_s = ST_IDLE;
        endcase
    end

    // State and registered outputs, derived from the next state so they align with it.
    always_ff @(posedge eph1) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            step_r   <= 3'd0;
            cnt_r    <= {CNT_W{1'b0}};
            prog_r   <= {(4*MAX_OPS){1'b0}};
            len_r    <= 4'd0;
            err_r    <= 1'b0;
            start_r  <= 1'b0;
            opmode_r <= 4'd0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= nxt_state_s;
            step_r   <= nxt_step_s;
            cnt_r    <= nxt_cnt_s;
            prog_r   <= nxt_prog_s;
            len_r    <= nxt_len_s;
            err_r    <= nxt_err_s;
            start_r  <= (nxt_state_s == ST_ISSUE) && (nxt_op_s[2:0] != 3'd0);
            opmode_r <= ((nxt_state_s == ST_ISSUE) || (nxt_state_s == ST_WAIT)) ? nxt_op_s : 4'd0;
            busy_r   <= (nxt_state_s == ST_ISSUE) || (nxt_state_s == ST_WAIT);
            done_r   <= (nxt_state_s == ST_DONE);
        end
    end

    // Ready is masked by reset so it stays low while reset is held.
    assign cmd_ready   = (state_r == ST_IDLE) && !reset;
    assign core_start  = start_r;
    assign core_opmode = opmode_r;
    assign seq_busy    = busy_r;
    assign seq_done    = done_r;
    assign seq_error   = err_r;
    assign step_idx    = step_r;

endmodule

// File: tb/tb_xoodyak_op_sequencer.sv
// Randomized bench for xoodyak_op_sequencer: a timeline model predicts every
// output on every cycle of each program run, including timeouts and resets.
module tb_xoodyak_op_sequencer;

    localparam int TO  = 64;
    localparam int MOP = 8;
    localparam int NC  = 1024;

    logic        eph1 = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_prog;
    logic [3:0]  cmd_len;
    logic        core_start;
    logic [3:0]  core_opmode;
    logic        core_finished;
    logic        seq_busy;
    logic        seq_done;
    logic        seq_error;
    logic [2:0]  step_idx;

    int n_cmp = 0;
    int n_bad = 0;
    int run_id = 0;

    logic [31:0] exp_v [NC];
    bit          fin_v [NC];
    int          dly   [MOP];
    bit          mdl_err;
    int          mdl_step;

    xoodyak_op_sequencer #(.TIMEOUT(TO), .MAX_OPS(MOP)) dut (
        .eph1(eph1), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_prog(cmd_prog), .cmd_len(cmd_len), .core_start(core_start),
        .core_opmode(core_opmode), .core_finished(core_finished), .seq_busy(seq_busy),
        .seq_done(seq_done), .seq_error(seq_error), .step_idx(step_idx)
    );

    always #5 eph1 = ~eph1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h (rdy,start,op,busy,done,err,step)", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] obs();
        return {20'd0, cmd_ready, core_start, core_opmode, seq_busy, seq_done, seq_error, step_idx};
    endfunction

    function automatic logic [31:0] pk(input bit rdy, input bit st, input logic [3:0] op,
                                       input bit bsy, input bit dn, input bit er, input int stp);
        return {20'd0, rdy, st, op, bsy, dn, er, 3'(stp)};
    endfunction

    // Builds the expected timeline for one program, then plays it cycle by cycle.
    task automatic run_prog(input logic [31:0] prog, input logic [3:0] len, input bit do_rst);
        int t, n, rst_cyc;
        bit aborted, got_fin;
        logic [3:0] op;
        for (int c = 0; c < NC; c++) begin
            exp_v[c] = 32'd0;
            fin_v[c] = 1'b0;
        end
        run_id++;
        rst_cyc = -1;
        exp_v[0] = pk(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, mdl_err, mdl_step);
        fin_v[0] = 1'($urandom_range(0, 1));
        if (len == 4'd0 || int'(len) > MOP || prog[2:0] != 3'd1) begin
            mdl_err = 1'b1;
            mdl_step = 0;
            exp_v[1] = pk(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 0);
            fin_v[1] = 1'($urandom_range(0, 1));
            n = 2;
        end else begin
            mdl_err = 1'b0;
            t = 1;
            aborted = 1'b0;
            for (int i = 0; i < int'(len); i++) begin
                op = prog[4*i +: 4];
                mdl_step = i;
                fin_v[t] = 1'($urandom_range(0, 1));
                if (op[2:0] == 3'd0) begin
                    exp_v[t] = pk(1'b0, 1'b0, op, 1'b1, 1'b0, 1'b0, i);
                    t = t + 1;
                end else begin
                    exp_v[t] = pk(1'b0, 1'b1, op, 1'b1, 1'b0, 1'b0, i);
                    if (do_rst && i == 1) rst_cyc = t + 2;
                    got_fin = 1'b0;
                    for (int w = 0; w < TO && !got_fin; w++) begin
                        exp_v[t+1+w] = pk(1'b0, 1'b0, op, 1'b1, 1'b0, 1'b0, i);
                        if (dly[i] == w + 1) begin
                            fin_v[t+1+w] = 1'b1;
                            got_fin = 1'b1;
                            t = t + 2 + w;
                        end
                    end
                    if (!got_fin) begin
                        exp_v[t+1+TO] = pk(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, i);
                        fin_v[t+1+TO] = 1'($urandom_range(0, 1));
                        mdl_err = 1'b1;
                        t = t + 2 + TO;
                        aborted = 1'b1;
                        break;
                    end
                end
            end
            if (!aborted) begin
                exp_v[t] = pk(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, int'(len) - 1);
                fin_v[t] = 1'($urandom_range(0, 1));
                t = t + 1;
            end
            n = t;
        end
        for (int c = 0; c < n; c++) begin
            @(negedge eph1);
            chk($sformatf("run%0d_cyc%0d", run_id, c), obs(), exp_v[c]);
            if (c == rst_cyc) begin
                reset = 1'b1;
                cmd_valid = 1'b0;
                core_finished = 1'b0;
                @(negedge eph1);
                chk($sformatf("run%0d_in_reset", run_id), obs(), 32'd0);
                reset = 1'b0;
                core_finished = 1'b1;
                @(negedge eph1);
                chk($sformatf("run%0d_late_fin", run_id), obs(), pk(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 0));
                core_finished = 1'b0;
                mdl_err = 1'b0;
                mdl_step = 0;
                return;
            end
            cmd_valid = (c == 0);
            cmd_prog = prog;
            cmd_len = len;
            core_finished = fin_v[c];
        end
        @(negedge eph1);
        cmd_valid = 1'b0;
        core_finished = 1'b0;
    endtask

    task automatic set_dly(input int d);
        for (int i = 0; i < MOP; i++) dly[i] = d;
    endtask

    initial begin
        logic [31:0] p;
        logic [3:0]  l;
        int r;
        reset = 1'b1;
        cmd_valid = 1'b0;
        cmd_prog = 32'd0;
        cmd_len = 4'd0;
        core_finished = 1'b0;
        @(posedge eph1);
        repeat (2) begin
            @(negedge eph1);
            chk("during_reset", obs(), 32'd0);
        end
        reset = 1'b0;
        #1;
        chk("ready_after_reset", obs(), pk(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 0));
        mdl_err = 1'b0;
        mdl_step = 0;

        set_dly(5);
        run_prog(32'h0000_4321, 4'd4, 1'b0);
        set_dly(3);
        run_prog(32'h0000_0601, 4'd3, 1'b0);
        run_prog(32'h0000_4322, 4'd4, 1'b0);
        run_prog(32'h0000_0001, 4'd0, 1'b0);
        run_prog(32'h1111_1111, 4'd9, 1'b0);
        set_dly(0);
        run_prog(32'h0000_0001, 4'd1, 1'b0);
        set_dly(TO);
        run_prog(32'h0000_0071, 4'd2, 1'b0);
        set_dly(10);
        run_prog(32'h0000_0531, 4'd3, 1'b1);
        set_dly(2);
        run_prog(32'h8765_4321, 4'd8, 1'b0);

        for (int k = 0; k < 40; k++) begin
            p = $urandom();
            if ($urandom_range(0, 9) != 0) p[2:0] = 3'd1;
            r = $urandom_range(0, 19);
            if (r == 0) l = 4'd0;
            else if (r < 3) l = 4'($urandom_range(9, 15));
            else l = 4'($urandom_range(1, 8));
            for (int i = 0; i < MOP; i++) begin
                r = $urandom_range(0, 29);
                if (r == 0) dly[i] = 0;
                else if (r == 1) dly[i] = TO;
                else dly[i] = $urandom_range(1, 6);
            end
            if (k % 10 == 9) begin
                p[6:4] = 3'd3;
                if (l < 4'd2 || l > 4'd8) l = 4'd3;
                dly[0] = 2;
                dly[1] = 10;
                run_prog(p, l, 1'b1);
            end else begin
                run_prog(p, l, 1'b0);
            end
        end

        @(negedge eph1);
        chk("final_idle", obs(), pk(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, mdl_err, mdl_step));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/xoodyak_op_sequencer.md
XOODYAK_OP_SEQUENCER -- requirements
Module: xoodyak_op_sequencer

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 64, giving the maximum WAIT cycles per operation before an error.
REQ-002 The block SHALL have parameter MAX_OPS, default 8, giving the program depth in opcodes.
REQ-003 eph1  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 cmd_valid  in  1  program offered.
REQ-006 cmd_ready  out  1  sequencer can accept a program.
REQ-007 cmd_prog  in  4*MAX_OPS  opcodes, op k in bits [4k+3:4k], k=0 issued first; bit 3 = continue, bits 2:0 = op (0 idle, 1 init, 2 nonce, 3 assoc, 4 crypt, 5 decrypt, 6 squeeze, 7 ratchet).
REQ-008 cmd_len  in  4  number of opcodes in program.
REQ-009 core_start  out  1  one-cycle start pulse to the Xoodyak core.
REQ-010 core_opmode  out  4  opcode presented to core.
REQ-011 core_finished  in  1  core completion pulse.
REQ-012 seq_busy  out  1  program in progress.
REQ-013 seq_done  out  1  one-cycle pulse, program completed.
REQ-014 seq_error  out  1  sticky error flag.
REQ-015 step_idx  out  3  index of current opcode.

Function
REQ-016 States SHALL be IDLE, ISSUE, WAIT, DONE, ERR.
REQ-017 cmd_ready SHALL equal (state==IDLE).
REQ-018 On cmd_valid&cmd_ready, the sequencer SHALL latch cmd_prog and cmd_len, clear seq_error, set step_idx=0, then go to ISSUE if the program is legal, else ERR.
REQ-019 A program SHALL be illegal if cmd_len==0, cmd_len>MAX_OPS, or op[0] bits 2:0 != 1.
REQ-020 In ISSUE with a current op of 0 (idle), the sequencer SHALL skip it: no core_start; advance as for completion (REQ-023).
REQ-021 In ISSUE with a nonzero op, the sequencer SHALL assert core_start for exactly that cycle, drive core_opmode = latched opcode[step_idx], clear the timeout counter, and go to WAIT.
REQ-022 core_opmode SHALL hold the current opcode from ISSUE through WAIT, and SHALL be 0 in IDLE, DONE and ERR.
REQ-023 In WAIT, on core_finished: if step_idx==cmd_len-1, go to DONE; else increment step_idx and go to ISSUE, giving the next core_start exactly 1 cycle after core_finished.
REQ-024 In WAIT without core_finished, the timeout counter SHALL increment; when it reaches TIMEOUT-1 without core_finished, the next state SHALL be ERR.
REQ-025 core_finished arriving in the same cycle as the terminal count SHALL count as completion, not timeout.
REQ-026 core_finished in IDLE, ISSUE, DONE or ERR SHALL be ignored.
REQ-027 DONE SHALL assert seq_done for one cycle, then go to IDLE.
REQ-028 ERR SHALL set seq_error, last one cycle, then go to IDLE; seq_error SHALL stay high until the next accepted program or reset.
REQ-029 seq_busy SHALL be 1 in ISSUE and WAIT, else 0.
REQ-030 The timeout counter SHALL be wide enough for TIMEOUT without wrap; step_idx SHALL never exceed cmd_len-1.
REQ-031 The accept-to-first-core_start latency SHALL be 1 cycle.

Reset
REQ-032 While reset is high, at each edge: state=IDLE, step_idx=0, timeout counter=0, seq_error=0, and all latched program fields=0.
REQ-033 During reset: core_start=0, core_opmode=0, seq_busy=0, seq_done=0, cmd_ready=0.
REQ-034 After reset, cmd_ready SHALL be 1 from the first cycle reset is low.
REQ-035 Reset asserted mid-program SHALL abort it with no further core_start and no seq_done.

Verification
REQ-036 Program {1,2,3,4}, len 4, core_finished 5 cycles after each start -> 4 core_start pulses with opmode 1,2,3,4; seq_done 1 cycle after the 4th finished; seq_error=0.
REQ-037 Program {1,0,6}, len 3 -> core_start only for ops 1 and 6; step_idx passes 1 with no pulse; seq_done asserted.
REQ-038 Program {2,...} (first op not init), or len 0, or len 9 -> no core_start; ERR for 1 cycle; seq_error=1 and held; cmd_ready=1 next cycle.
REQ-039 TIMEOUT=64, core_finished withheld -> ERR after 64 WAIT cycles; seq_error=1; a following legal program clears seq_error on accept.
REQ-040 Reset pulsed during WAIT of op 2 -> all outputs 0 next cycle; a late core_finished is ignored; a new program runs normally.
REQ-041 core_finished pulsed in IDLE and in the ISSUE cycle -> no state change and no early advance.
